// File: rtl/ibex_mem_resp_pkg.sv
// Shared types and width helpers for the Ibex memory responder.
// Entry age width LW bounds the supported MIN_LATENCY (<= 2**LW - 1).
package ibex_mem_resp_pkg;

   localparam int unsigned LW = 8;

   typedef struct packed {
      logic [31:0]   rdata;
      logic          err;
      logic [LW-1:0] age;
   } resp_entry_t;

   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ibex_mem_resp_fifo.sv
// In-order circular queue of pending responses with per-entry age tracking.
// The head is ready once its age has reached MIN_LATENCY.
module ibex_mem_resp_fifo
   import ibex_mem_resp_pkg::*;
#(
   parameter int unsigned DEPTH       = 2,
   parameter int unsigned MIN_LATENCY = 1,
   parameter int unsigned CW          = cnt_width(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic [31:0]   push_rdata_i,
   input  logic          push_err_i,
   input  logic          pop_i,
   output logic          head_ready_o,
   output logic [31:0]   head_rdata_o,
   output logic          head_err_o,
   output logic [CW-1:0] count_o
);

   localparam int unsigned   PW      = ptr_width(DEPTH);
   localparam logic [LW-1:0] AGE_MAX = LW'(MIN_LATENCY);

   resp_entry_t    entry_q [DEPTH];
   resp_entry_t    entry_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           push_ok, pop_ok;
   resp_entry_t    head;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign push_ok = push_i & ~valid_q[wr_ptr_q];
   assign pop_ok  = pop_i & valid_q[rd_ptr_q];

   always_comb begin
      entry_d  = entry_q;
      valid_d  = valid_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (entry_q[i].age != AGE_MAX)) begin
            entry_d[i].age = entry_q[i].age + LW'(1);
         end
      end
      if (pop_ok) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = next_ptr(rd_ptr_q);
      end
      // Stored age already includes the grant cycle, so MIN_LATENCY=1 answers on the next cycle.
      if (push_ok) begin
         entry_d[wr_ptr_q].rdata = push_rdata_i;
         entry_d[wr_ptr_q].err   = push_err_i;
         entry_d[wr_ptr_q].age   = LW'(1);
         valid_d[wr_ptr_q]       = 1'b1;
         wr_ptr_d                = next_ptr(wr_ptr_q);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
         end
         valid_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         entry_q  <= entry_d;
         valid_q  <= valid_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head         = entry_q[rd_ptr_q];
   assign head_ready_o = valid_q[rd_ptr_q] & (head.age == AGE_MAX);
   assign head_rdata_o = head.rdata;
   assign head_err_o   = head.err;
   assign count_o      = count_q;

endmodule

// File: rtl/ibex_mem_responder.sv
// Memory-side responder for the Ibex req/gnt/rvalid bus: word memory, grant
// throttling, error decode and in-order delayed responses.
module ibex_mem_responder
   import ibex_mem_resp_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS     = 256,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned MIN_LATENCY     = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   input  logic        gnt_stall_i,
   input  logic        rvalid_stall_i,
   input  logic        err_inject_i,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

   localparam int unsigned IW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = cnt_width(MAX_OUTSTANDING);

   logic [31:0]   mem_q [DEPTH_WORDS];
   logic [IW-1:0] idx;
   logic          oob, accept, req_err;
   logic [31:0]   push_rdata;
   logic [CW-1:0] count;
   logic          head_ready, head_err;
   logic [31:0]   head_rdata;
   logic          unused_addr;

   assign unused_addr = ^addr_i[1:0];
   assign idx         = addr_i[2+:IW];
   assign oob         = |addr_i[31:2+IW];
   assign req_err     = err_inject_i | oob;

   // Full queue blocks grant even if the head retires this cycle.
   assign gnt_o  = rst_ni & req_i & ~gnt_stall_i & (count < CW'(MAX_OUTSTANDING));
   assign accept = req_i & gnt_o;

   assign push_rdata = (we_i | req_err) ? '0 : mem_q[idx];

   always_ff @(posedge clk_i) begin
      if (accept && we_i && !req_err) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (be_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   ibex_mem_resp_fifo #(
      .DEPTH       (MAX_OUTSTANDING),
      .MIN_LATENCY (MIN_LATENCY),
      .CW          (CW)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_i       (accept),
      .push_rdata_i (push_rdata),
      .push_err_i   (req_err),
      .pop_i        (rvalid_o),
      .head_ready_o (head_ready),
      .head_rdata_o (head_rdata),
      .head_err_o   (head_err),
      .count_o      (count)
   );

   assign rvalid_o      = head_ready & ~rvalid_stall_i;
   assign rdata_o       = rvalid_o ? head_rdata : '0;
   assign err_o         = rvalid_o & head_err;
   assign outstanding_o = count;

`ifdef FORMAL
   always_comb begin
      assert (outstanding_o <= CW'(MAX_OUTSTANDING));
      assert (!(rvalid_o && (count == '0)));
      assert (!gnt_o || req_i);
   end
`endif

endmodule
